// File: rtl/pwm_pkg.sv
// Shared defaults, state encodings and reset helpers for the triangular-carrier PWM block.
package pwm_pkg;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_DUTY_WIDTH = 8;
    localparam int DEF_DT_WIDTH   = 4;

    // Carrier counting direction
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } carrier_dir_e;

    // Per-channel dead-time sequencer states
    typedef enum logic [1:0] {
        DT_OFF   = 2'd0,
        DT_DEAD  = 2'd1,
        DT_DRIVE = 2'd2
    } dt_state_e;

    // Out of reset the active carrier peak is the largest value the counter can hold
    function automatic logic [63:0] period_reset_value(input int unsigned width);
        return ~(64'hFFFF_FFFF_FFFF_FFFF << width);
    endfunction

    localparam logic [DEF_DUTY_WIDTH-1:0] DEF_PERIOD_RESET =
        DEF_DUTY_WIDTH'(period_reset_value(DEF_DUTY_WIDTH));

endpackage

// File: rtl/pwm_deadtime.sv
// One PWM channel: turns a raw compare level into complementary hi/lo drives,
// inserting a dead-time gap (both low) before every change of driven state.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = DEF_DT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                raw,
    input  logic [DT_WIDTH-1:0] deadtime,
    output logic                pwm_hi,
    output logic                pwm_lo
);

    localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);

    dt_state_e           state, state_nxt;
    logic                level, level_nxt;
    logic [DT_WIDTH-1:0] dt_cnt, dt_cnt_nxt;
    logic                hi_nxt, lo_nxt;

    // State, remembered target level, remaining dead cycles and both drive outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DT_OFF;
            level  <= 1'b0;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            state  <= state_nxt;
            level  <= level_nxt;
            dt_cnt <= dt_cnt_nxt;
            pwm_hi <= hi_nxt;
            pwm_lo <= lo_nxt;
        end
    end

    // Leaving OFF is treated like a level change, so the first drive after enable
    // (or reset) also waits out the dead time; a new change restarts the gap
    always_comb begin
        state_nxt  = state;
        level_nxt  = level;
        dt_cnt_nxt = dt_cnt;
        hi_nxt     = 1'b0;
        lo_nxt     = 1'b0;
        if (!enable) begin
            state_nxt  = DT_OFF;
            dt_cnt_nxt = '0;
        end else if ((state == DT_OFF) || (raw != level)) begin
            level_nxt = raw;
            if (deadtime == '0) begin
                state_nxt  = DT_DRIVE;
                dt_cnt_nxt = '0;
                hi_nxt     = raw;
                lo_nxt     = ~raw;
            end else begin
                state_nxt  = DT_DEAD;
                dt_cnt_nxt = deadtime;
            end
        end else begin
            unique case (state)
                DT_DEAD: begin
                    if (dt_cnt > DT_ONE) begin
                        dt_cnt_nxt = dt_cnt - DT_ONE;
                    end else begin
                        state_nxt  = DT_DRIVE;
                        dt_cnt_nxt = '0;
                        hi_nxt     = level;
                        lo_nxt     = ~level;
                    end
                end
                DT_DRIVE: begin
                    hi_nxt = level;
                    lo_nxt = ~level;
                end
                default: begin
                    state_nxt  = DT_OFF;
                    dt_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_triangular_pwm.sv
// Multi-channel PWM sharing one up/down triangular carrier, with shadowed
// period/duty/dead-time that only take effect at a carrier valley.
module multi_triangular_pwm
    import pwm_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DUTY_WIDTH = DEF_DUTY_WIDTH,
    parameter int DT_WIDTH   = DEF_DT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [DUTY_WIDTH-1:0]          period,
    input  logic [CHANNELS*DUTY_WIDTH-1:0] duty,
    input  logic [DT_WIDTH-1:0]            deadtime,
    input  logic                           update_req,
    output logic                           update_ack,
    output logic [CHANNELS-1:0]            pwm_hi,
    output logic [CHANNELS-1:0]            pwm_lo,
    output logic                           valley
);

    localparam logic [DUTY_WIDTH-1:0] PERIOD_RST =
        DUTY_WIDTH'(period_reset_value($unsigned(DUTY_WIDTH)));
    localparam logic [DUTY_WIDTH-1:0] CNT_ONE = DUTY_WIDTH'(1);

    logic [DUTY_WIDTH-1:0]          act_period, shd_period;
    logic [CHANNELS*DUTY_WIDTH-1:0] act_duty, shd_duty;
    logic [DT_WIDTH-1:0]            act_deadtime, shd_deadtime;
    logic                           pending;

    logic [DUTY_WIDTH-1:0] count, count_nxt;
    carrier_dir_e          dir, dir_nxt;
    logic                  apply_now;
    logic [DUTY_WIDTH-1:0] eff_period;
    logic [CHANNELS-1:0]   raw;

    // Shadow values are swapped in only at an enabled valley; the peak used for the
    // step out of that valley is already the new one
    assign apply_now  = enable && (count == '0) && pending;
    assign eff_period = apply_now ? shd_period : act_period;

    // Shadow capture and valley-synchronous promotion to the active set; a request on
    // the promoting cycle refills the shadow and stays pending for the next valley
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_period   <= PERIOD_RST;
            act_duty     <= '0;
            act_deadtime <= '0;
            shd_period   <= PERIOD_RST;
            shd_duty     <= '0;
            shd_deadtime <= '0;
            pending      <= 1'b0;
        end else begin
            if (apply_now) begin
                act_period   <= shd_period;
                act_duty     <= shd_duty;
                act_deadtime <= shd_deadtime;
            end
            if (update_req) begin
                shd_period   <= period;
                shd_duty     <= duty;
                shd_deadtime <= deadtime;
                pending      <= 1'b1;
            end else if (apply_now) begin
                pending      <= 1'b0;
            end
        end
    end

    // Carrier next state: 0,1..P,P-1..1,0,...; a zero peak parks the count at 0
    always_comb begin
        count_nxt = count;
        dir_nxt   = dir;
        if (!enable || (eff_period == '0)) begin
            count_nxt = '0;
            dir_nxt   = DIR_UP;
        end else begin
            unique case (dir)
                DIR_UP: begin
                    if (count >= eff_period) begin
                        count_nxt = count - CNT_ONE;
                        dir_nxt   = (count == CNT_ONE) ? DIR_UP : DIR_DOWN;
                    end else begin
                        count_nxt = count + CNT_ONE;
                    end
                end
                DIR_DOWN: begin
                    count_nxt = (count == '0) ? CNT_ONE : count - CNT_ONE;
                    dir_nxt   = (count <= CNT_ONE) ? DIR_UP : DIR_DOWN;
                end
                default: begin
                    count_nxt = '0;
                    dir_nxt   = DIR_UP;
                end
            endcase
        end
    end

    // Carrier register plus registered valley (aligned with count==0) and ack (one cycle later)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            dir        <= DIR_UP;
            valley     <= 1'b0;
            update_ack <= 1'b0;
        end else begin
            count      <= count_nxt;
            dir        <= dir_nxt;
            valley     <= enable && (count_nxt == '0);
            update_ack <= apply_now;
        end
    end

    // Per-channel compare of the carrier against the active duty
    always_comb begin
        raw = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            raw[i] = (count < act_duty[i*DUTY_WIDTH +: DUTY_WIDTH]);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pwm_deadtime #(
            .DT_WIDTH (DT_WIDTH)
        ) u_deadtime (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable   (enable),
            .raw      (raw[g]),
            .deadtime (act_deadtime),
            .pwm_hi   (pwm_hi[g]),
            .pwm_lo   (pwm_lo[g])
        );
    end

endmodule
